// File: rtl/shift_commit_stage_if.sv
// Handshake and bus bundle between the barrel shifter, the commit stage, the register file and decode.
// The master side is the upstream shifter/driver and the slave side is the commit stage.
interface shift_commit_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_shifted_i;
    logic              negative_i;
    logic              zero_i;
    logic              carry_i;
    logic              amt_zero_i;
    logic              setflags_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              flush_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [3:0]        flags_o;
    logic [ADDR_W-1:0] hazard_addr_i;
    logic              hazard_o;

    modport master (
        output valid_i, data_shifted_i, negative_i, zero_i, carry_i, amt_zero_i,
               setflags_i, rd_addr_i, flush_i, wb_ready_i, hazard_addr_i,
        input  ready_o, wb_valid_o, wb_addr_o, wb_data_o, flags_o, hazard_o
    );

    modport slave (
        input  valid_i, data_shifted_i, negative_i, zero_i, carry_i, amt_zero_i,
               setflags_i, rd_addr_i, flush_i, wb_ready_i, hazard_addr_i,
        output ready_o, wb_valid_o, wb_addr_o, wb_data_o, flags_o, hazard_o
    );
endinterface

// File: rtl/shift_commit_stage.sv
// Two-entry in-order commit buffer behind the barrel shifter: register-file writeback,
// architectural NZCV update on commit, and a RAW hazard check for decode.
module shift_commit_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    shift_commit_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              n;
        logic              z;
        logic              c;
        logic              amt_zero;
        logic              setflags;
        logic [ADDR_W-1:0] rd;
    } entry_t;

    state_t     state_q, state_nxt;
    entry_t     head_q, head_nxt;   // slot 0: oldest entry, drives wb_* directly
    entry_t     tail_q, tail_nxt;   // slot 1: second entry when full
    entry_t     in_entry;
    logic [3:0] flags_q, flags_nxt;
    logic       ready_q, ready_nxt;
    logic       wb_valid_q, wb_valid_nxt;
    logic       push, pop;

    assign in_entry = '{data:     bus.data_shifted_i,
                        n:        bus.negative_i,
                        z:        bus.zero_i,
                        c:        bus.carry_i,
                        amt_zero: bus.amt_zero_i,
                        setflags: bus.setflags_i,
                        rd:       bus.rd_addr_i};

    assign push = bus.valid_i && ready_q;
    assign pop  = wb_valid_q && bus.wb_ready_i;

    // State register plus all registered datapath/outputs.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            flags_q    <= 4'b0000;
            ready_q    <= 1'b1;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            head_q     <= head_nxt;
            tail_q     <= tail_nxt;
            flags_q    <= flags_nxt;
            ready_q    <= ready_nxt;
            wb_valid_q <= wb_valid_nxt;
        end
    end

    // Occupancy FSM, slot shifting and commit-time flag update.
    always_comb begin
        state_nxt = state_q;
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        flags_nxt = flags_q;

        if (bus.flush_i) begin
            // Slots keep their contents so wb_* hold their last values.
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_nxt  = in_entry;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_nxt = in_entry;
                    end else if (push) begin
                        tail_nxt  = in_entry;
                        state_nxt = ST_FULL;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_nxt  = tail_q;
                        state_nxt = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase

            if (pop && head_q.setflags) begin
                flags_nxt[3] = head_q.n;
                flags_nxt[2] = head_q.z;
                // A zero shift amount leaves C untouched; V is never written by shifts.
                if (!head_q.amt_zero) begin
                    flags_nxt[1] = head_q.c;
                end
            end
        end

        ready_nxt    = (state_nxt != ST_FULL);
        wb_valid_nxt = (state_nxt != ST_EMPTY);
    end

    assign bus.ready_o    = ready_q;
    assign bus.wb_valid_o = wb_valid_q;
    assign bus.wb_addr_o  = head_q.rd;
    assign bus.wb_data_o  = head_q.data;
    assign bus.flags_o    = flags_q;

    // Combinational RAW check against every occupied slot.
    assign bus.hazard_o = ((state_q != ST_EMPTY) && (head_q.rd == bus.hazard_addr_i)) ||
                          ((state_q == ST_FULL)  && (tail_q.rd == bus.hazard_addr_i));
endmodule
